// File: rtl/bnn_acc_cxu.sv
// bnn_acc_cxu
// Serial binary-neural-network dot-product unit behind a CFU request/response
// handshake. It computes popcount(a ~^ b) over DATA_W bits, CHUNK_W bits per
// cycle, and keeps a saturating accumulator that persists between requests.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_func            function ID: 0 BNN, 1 BNN_ACC, 2 BNN_SIGNED,
//                       3 ACC_READ, 4 ACC_CLEAR, 5-7 illegal
//   req_data0/1         operands a and b
//   resp_valid/ready    response handshake
//   resp_status         0 = OK, 1 = illegal function
//   resp_data           result, held stable until the response is taken
module bnn_acc_cxu #(
    parameter int DATA_W    = 32,
    parameter int CHUNK_W   = 8,
    parameter int ACC_W     = 32,
    parameter int FUNC_ID_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [FUNC_ID_W-1:0] req_func,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           resp_status,
    output logic [DATA_W-1:0]    resp_data
);

    localparam int N     = DATA_W / CHUNK_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int CHK_W = (N > 1) ? $clog2(N) : 1;
    // One bit wider than either addend so an overflow past the accumulator
    // range is visible and can be clamped.
    localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;

    localparam logic [FUNC_ID_W-1:0] FUNC_BNN        = FUNC_ID_W'(0);
    localparam logic [FUNC_ID_W-1:0] FUNC_BNN_ACC    = FUNC_ID_W'(1);
    localparam logic [FUNC_ID_W-1:0] FUNC_BNN_SIGNED = FUNC_ID_W'(2);
    localparam logic [FUNC_ID_W-1:0] FUNC_ACC_READ   = FUNC_ID_W'(3);
    localparam logic [FUNC_ID_W-1:0] FUNC_ACC_CLEAR  = FUNC_ID_W'(4);

    generate
        if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
            $error("bnn_acc_cxu: CHUNK_W must divide DATA_W");
        end
        if (ACC_W > DATA_W) begin : g_bad_acc
            $error("bnn_acc_cxu: ACC_W must not exceed DATA_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CHK_W-1:0]       chunk_q, chunk_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [FUNC_ID_W-1:0]   func_q, func_d;
    logic [DATA_W-1:0]      resp_data_q, resp_data_d;
    logic [2:0]             resp_status_q, resp_status_d;

    logic [CNT_W-1:0]       chunk_pop;
    logic [CNT_W-1:0]       count_sum;
    logic [SUM_W-1:0]       acc_sum;
    logic [ACC_W-1:0]       acc_sat;
    logic [DATA_W-1:0]      signed_res;

    // Popcount of the chunk currently sitting in the low bits of the shift
    // register, plus the arithmetic that finishes each counting function.
    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            chunk_pop = chunk_pop + CNT_W'(shift_q[i]);
        end
        count_sum = count_q + chunk_pop;
        acc_sum   = SUM_W'(acc_q) + SUM_W'(count_sum);
        if (|acc_sum[SUM_W-1:ACC_W]) begin
            acc_sat = '1;
        end else begin
            acc_sat = acc_sum[ACC_W-1:0];
        end
        // 2*count - DATA_W, wrapping naturally into two's complement.
        signed_res = (DATA_W'(count_sum) << 1) - DATA_W'(DATA_W);
    end

    // Next-state logic. Results are only written at acceptance (non-counting
    // functions) or on the last counting edge, so resp_data/resp_status stay
    // frozen for the whole RESP state regardless of backpressure.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        count_d       = count_q;
        chunk_d       = chunk_q;
        acc_d         = acc_q;
        func_d        = func_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    func_d  = req_func;
                    count_d = '0;
                    if (req_func <= FUNC_BNN_SIGNED) begin
                        shift_d = req_data0 ~^ req_data1;
                        chunk_d = CHK_W'(N - 1);
                        state_d = COUNT;
                    end else begin
                        state_d = RESP;
                        if (req_func == FUNC_ACC_READ) begin
                            resp_data_d   = DATA_W'(acc_q);
                            resp_status_d = 3'd0;
                        end else if (req_func == FUNC_ACC_CLEAR) begin
                            resp_data_d   = DATA_W'(acc_q);
                            resp_status_d = 3'd0;
                            acc_d         = '0;
                        end else begin
                            resp_data_d   = '0;
                            resp_status_d = 3'd1;
                        end
                    end
                end
            end

            COUNT: begin
                shift_d = shift_q >> CHUNK_W;
                count_d = count_sum;
                if (chunk_q == '0) begin
                    state_d       = RESP;
                    resp_status_d = 3'd0;
                    if (func_q == FUNC_BNN_ACC) begin
                        acc_d       = acc_sat;
                        resp_data_d = DATA_W'(acc_sat);
                    end else if (func_q == FUNC_BNN_SIGNED) begin
                        resp_data_d = signed_res;
                    end else begin
                        resp_data_d = DATA_W'(count_sum);
                    end
                end else begin
                    chunk_d = chunk_q - CHK_W'(1);
                end
            end

            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation and clears the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            count_q       <= '0;
            chunk_q       <= '0;
            acc_q         <= '0;
            func_q        <= FUNC_BNN;
            resp_data_q   <= '0;
            resp_status_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            count_q       <= count_d;
            chunk_q       <= chunk_d;
            acc_q         <= acc_d;
            func_q        <= func_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;

endmodule
